f1_reaction_timer: RTL and testbench
====================================

// Module: f1_reaction_timer
// PURPOSE
//  Sits downstream of the F1 start-light sequencer; it consumes the sequencer's 8-bit lights output.
//  Gates the sequencer's enable. When all lights are on, it waits a pseudo-random number of ticks,
//  then commands lights-out and measures the driver's reaction time until a button press.
//  It reports a valid reaction time, or flags a false start if the button is pressed before lights-out.
// PARAMETERS
//  MS_DIV   1000  clk cycles per reaction-time count (one count = 1 ms at 1 MHz clk)
//  TIME_W   16    width of react_time; the counter saturates at all-ones
// PORTS
//  clk         in   1       system clock; all logic on posedge
//  rst         in   1       synchronous, ACTIVE-LOW reset (0 = reset)
//  start       in   1       1-cycle pulse; arms a new run (honoured in IDLE and DONE only)
//  tick        in   1       1-cycle pacing pulse (same strobe that paces the sequencer)
//  button      in   1       driver button, already synchronised to clk, level-high = pressed
//  lights      in   8       sequencer output; 8'hFF = all lights on
//  seq_run     out  1       sequencer enable gate; sequencer en = tick & seq_run
//  seq_clr     out  1       1-cycle pulse; drives sequencer reset to blank the lights
//  lights_out  out  1       1-cycle pulse; the cycle the delay expires
//  react_time  out  TIME_W  reaction time in ms; held in DONE
//  react_valid out  1       1-cycle pulse when react_time is final
//  false_start out  1       level; set on an early press, cleared on the next accepted start
//  busy        out  1       high in ARMED, DELAY, TIMING
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, all outputs 0, lfsr=7'h01, btn_q=0, prescaler=0.
//  press = button & ~btn_q (rising edge); btn_q <= button every cycle.
//  LFSR: 7-bit, free-running every non-reset cycle.
//   - Update: lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}. Period 127; the value never reaches 0.
//  FSM states: IDLE, ARMED, DELAY, TIMING, DONE. All outputs are registered.
//  IDLE:
//   - start -> ARMED.
//  ARMED: seq_run=1.
//   - press -> DONE, false_start=1, seq_clr pulse. This takes priority.
//   - else lights==8'hFF -> DELAY; dly_cnt<=lfsr (1..127); seq_run drops that edge.
//  DELAY: seq_run=0, so the lights hold at 8'hFF.
//   - press -> DONE, false_start=1, seq_clr pulse. This takes priority over expiry.
//   - else on tick: if dly_cnt==1 -> TIMING, lights_out and seq_clr pulse,
//     react_time<=0, prescaler<=0; otherwise dly_cnt<=dly_cnt-1.
//   - A tick with no expiry does nothing else.
//  TIMING:
//   - prescaler counts 0..MS_DIV-1 and wraps to 0.
//   - On wrap, react_time += 1, saturating at all-ones. There is no timeout; the block stays in TIMING.
//   - press -> DONE, react_valid pulse, react_time frozen. No increment on the press cycle.
//   - A press in the same cycle as lights_out is impossible: that cycle is still DELAY, so it is a false start.
//  DONE:
//   - Outputs held.
//   - start -> ARMED; react_time<=0, false_start<=0.
//  start is ignored in ARMED, DELAY and TIMING. Presses in IDLE and DONE are ignored.
//  Latency:
//   - press to react_valid/DONE: 1 cycle.
//   - Expiring tick to lights_out: 1 cycle (registered pulse).
//  Reset mid-run (any state) -> IDLE next edge. Any in-flight pulse is dropped. The LFSR reseeds to 7'h01.
// TESTING (bench uses MS_DIV=4 and mirrors the LFSR to predict delays)
//  1 Reset: hold rst=0 for 3 cycles. All outputs are 0. After release, lfsr steps 01,02,04,08,10,20,41,03.
//  2 Normal run: start, then lights reach FF while lfsr=0x05.
//    - lights_out pulses 1 cycle after the 5th subsequent tick.
//    - Press 40 cycles after lights_out -> react_time=10, react_valid for 1 cycle, busy=0.
//  3 False start in ARMED: press while lights=8'h07 -> false_start=1, seq_clr pulse, DONE, no react_valid.
//  4 Simultaneous: press on the cycle of the expiring tick in DELAY -> false_start=1, no lights_out.
//  5 Saturation: with TIME_W=4 and no press for 80 cycles -> react_time sticks at 4'hF.
//    - A later press -> react_valid, react_time=4'hF.
//  6 start ignored while busy. Reset asserted mid-TIMING -> IDLE, react_time=0.
//    - A new start re-arms cleanly; seq_run=1 the next cycle.

Source files
------------

// File: rtl/f1_reaction_timer.sv
// Reaction timer for the F1 start-light game: gates the light sequencer, inserts a
// pseudo-random hold after all lights are on, then times the driver's button press.
module f1_reaction_timer #(
    parameter int unsigned MS_DIV = 1000,
    parameter int unsigned TIME_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_tick,
    input  logic              i_button,
    input  logic [7:0]        i_lights,
    output logic              o_seq_run,
    output logic              o_seq_clr,
    output logic              o_lights_out,
    output logic [TIME_W-1:0] o_react_time,
    output logic              o_react_valid,
    output logic              o_false_start,
    output logic              o_busy
);

    localparam int unsigned PRE_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int unsigned LFSR_W  = 7;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(MS_DIV - 1);
    localparam logic [TIME_W-1:0] TIME_MAX = '1;
    localparam logic [7:0]        ALL_ON   = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_TIMING,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [LFSR_W-1:0]   r_dly_cnt;
    logic [PRE_W-1:0]    r_prescaler;
    logic                r_btn_q;
    logic                r_seq_run;
    logic                r_seq_clr;
    logic                r_lights_out;
    logic [TIME_W-1:0]   r_react_time;
    logic                r_react_valid;
    logic                r_false_start;
    logic                r_busy;
    logic                w_press;

    assign w_press = i_button & ~r_btn_q;

    // Single-process FSM; pulses default low every cycle and are raised for one edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_lfsr        <= LFSR_W'(1);
            r_dly_cnt     <= '0;
            r_prescaler   <= '0;
            r_btn_q       <= 1'b0;
            r_seq_run     <= 1'b0;
            r_seq_clr     <= 1'b0;
            r_lights_out  <= 1'b0;
            r_react_time  <= '0;
            r_react_valid <= 1'b0;
            r_false_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_btn_q       <= i_button;
            r_lfsr        <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
            r_seq_clr     <= 1'b0;
            r_lights_out  <= 1'b0;
            r_react_valid <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state       <= S_ARMED;
                        r_seq_run     <= 1'b1;
                        r_busy        <= 1'b1;
                        r_react_time  <= '0;
                        r_false_start <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (w_press) begin
                        r_state       <= S_DONE;
                        r_false_start <= 1'b1;
                        r_seq_clr     <= 1'b1;
                        r_seq_run     <= 1'b0;
                        r_busy        <= 1'b0;
                    end else if (i_lights == ALL_ON) begin
                        r_state   <= S_DELAY;
                        r_dly_cnt <= r_lfsr;
                        r_seq_run <= 1'b0;
                    end
                end
                S_DELAY: begin
                    // A press here, even on the expiring tick, is a false start.
                    if (w_press) begin
                        r_state       <= S_DONE;
                        r_false_start <= 1'b1;
                        r_seq_clr     <= 1'b1;
                        r_busy        <= 1'b0;
                    end else if (i_tick) begin
                        if (r_dly_cnt == LFSR_W'(1)) begin
                            r_state      <= S_TIMING;
                            r_lights_out <= 1'b1;
                            r_seq_clr    <= 1'b1;
                            r_react_time <= '0;
                            r_prescaler  <= '0;
                        end else begin
                            r_dly_cnt <= r_dly_cnt - LFSR_W'(1);
                        end
                    end
                end
                S_TIMING: begin
                    if (w_press) begin
                        r_state       <= S_DONE;
                        r_react_valid <= 1'b1;
                        r_busy        <= 1'b0;
                    end else if (r_prescaler == PRE_MAX) begin
                        r_prescaler <= '0;
                        if (r_react_time != TIME_MAX) begin
                            r_react_time <= r_react_time + TIME_W'(1);
                        end
                    end else begin
                        r_prescaler <= r_prescaler + PRE_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_seq_run     = r_seq_run;
    assign o_seq_clr     = r_seq_clr;
    assign o_lights_out  = r_lights_out;
    assign o_react_time  = r_react_time;
    assign o_react_valid = r_react_valid;
    assign o_false_start = r_false_start;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Randomized bench for f1_reaction_timer; predicts delays from the LFSR sequence and
// reaction times from elapsed cycles.
module tb_f1_reaction_timer;

    localparam int unsigned MS_DIV = 4;
    localparam int unsigned TIME_W = 4;
    localparam int          T_SAT  = (1 << TIME_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              tick = 1'b0;
    logic              button = 1'b0;
    logic [7:0]        lights = 8'h00;
    logic              seq_run;
    logic              seq_clr;
    logic              lights_out;
    logic [TIME_W-1:0] react_time;
    logic              react_valid;
    logic              false_start;
    logic              busy;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_lfsr   = 0;
    logic [6:0] seq [127];

    f1_reaction_timer #(.MS_DIV(MS_DIV), .TIME_W(TIME_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .i_tick       (tick),
        .i_button     (button),
        .i_lights     (lights),
        .o_seq_run    (seq_run),
        .o_seq_clr    (seq_clr),
        .o_lights_out (lights_out),
        .o_react_time (react_time),
        .o_react_valid(react_valid),
        .o_false_start(false_start),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    // Number of LFSR steps taken since the last reset edge.
    always @(posedge clk) n_lfsr <= rst ? n_lfsr + 1 : 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_time(input int edges);
        int t;
        t = edges / int'(MS_DIV);
        return (t > T_SAT) ? T_SAT : t;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_seq_run"}, 32'(seq_run), 0);
        chk({tag, "_seq_clr"}, 32'(seq_clr), 0);
        chk({tag, "_lights_out"}, 32'(lights_out), 0);
        chk({tag, "_react_time"}, 32'(react_time), 0);
        chk({tag, "_react_valid"}, 32'(react_valid), 0);
        chk({tag, "_false_start"}, 32'(false_start), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic idle_gap();
        int n;
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            button = 1'($urandom_range(0, 1));
            tick   = 1'($urandom_range(0, 1));
            step();
            chk("gap_busy", 32'(busy), 0);
            chk("gap_valid", 32'(react_valid), 0);
        end
        button = 1'b0;
        tick   = 1'b0;
        step();
    endtask

    task automatic arm();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("arm_seq_run", 32'(seq_run), 1);
        chk("arm_busy", 32'(busy), 1);
        chk("arm_false_start", 32'(false_start), 0);
        chk("arm_react_time", 32'(react_time), 0);
    endtask

    task automatic armed_wander();
        int n;
        n = $urandom_range(0, 5);
        for (int i = 0; i < n; i++) begin
            lights = 8'($urandom_range(0, 254));
            tick   = 1'($urandom_range(0, 1));
            start  = 1'($urandom_range(0, 1));
            step();
            chk("armed_seq_run", 32'(seq_run), 1);
        end
        start = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic to_delay(output int d);
        armed_wander();
        lights = 8'hFF;
        d = int'(seq[n_lfsr % 127]);
        step();
        chk("delay_seq_run", 32'(seq_run), 0);
        chk("delay_busy", 32'(busy), 1);
    endtask

    task automatic chk_false_start();
        chk("fs_flag", 32'(false_start), 1);
        chk("fs_seq_clr", 32'(seq_clr), 1);
        chk("fs_lights_out", 32'(lights_out), 0);
        chk("fs_valid", 32'(react_valid), 0);
        chk("fs_busy", 32'(busy), 0);
        chk("fs_seq_run", 32'(seq_run), 0);
        button = 1'b0;
        step();
        chk("fs_clr_pulse", 32'(seq_clr), 0);
        chk("fs_held", 32'(false_start), 1);
    endtask

    // mode 0: run to expiry; 1: press after k ticks; 2: press on the expiring tick.
    task automatic run_delay(input int d, input int mode, output bit expired);
        int  ticks = 0;
        int  k;
        bit  done = 1'b0;
        k = $urandom_range(0, d - 1);
        expired = 1'b0;
        for (int g = 0; g < 2000 && !done; g++) begin
            tick = 1'($urandom_range(0, 1));
            if ((mode == 1 && ticks == k) || (mode == 2 && ticks == d - 1)) begin
                if (mode == 2) tick = 1'b1;
                button = 1'b1;
                step();
                tick = 1'b0;
                chk_false_start();
                done = 1'b1;
            end else begin
                step();
                if (tick) ticks++;
                if (ticks == d) begin
                    chk("lo_pulse", 32'(lights_out), 1);
                    chk("lo_seq_clr", 32'(seq_clr), 1);
                    chk("lo_react_time", 32'(react_time), 0);
                    chk("lo_busy", 32'(busy), 1);
                    expired = 1'b1;
                    done = 1'b1;
                end else begin
                    chk("lo_early", 32'(lights_out), 0);
                end
            end
        end
        tick = 1'b0;
        if (!done) chk("delay_timeout", 0, 1);
    endtask

    task automatic run_timing(input int r);
        for (int i = 0; i < r; i++) begin
            start = 1'($urandom_range(0, 1));
            tick  = 1'($urandom_range(0, 1));
            step();
            chk("tm_busy", 32'(busy), 1);
            chk("tm_react_time", 32'(react_time), 32'(exp_time(i + 1)));
        end
        start  = 1'b0;
        tick   = 1'b0;
        button = 1'b1;
        step();
        chk("rv_pulse", 32'(react_valid), 1);
        chk("rv_time", 32'(react_time), 32'(exp_time(r)));
        chk("rv_busy", 32'(busy), 0);
        chk("rv_false_start", 32'(false_start), 0);
        step();
        chk("rv_one_cycle", 32'(react_valid), 0);
        chk("rv_held", 32'(react_time), 32'(exp_time(r)));
        button = 1'b0;
        step();
    endtask

    task automatic normal_run(input int r);
        int d;
        bit ok;
        arm();
        to_delay(d);
        run_delay(d, 0, ok);
        if (ok) run_timing(r);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d;
        int kind;
        bit ok;
        seq[0] = 7'h01;
        for (int i = 1; i < 127; i++) seq[i] = {seq[i-1][5:0], seq[i-1][6] ^ seq[i-1][5]};

        for (int i = 0; i < 3; i++) begin
            step();
            chk_all_zero("reset");
        end
        rst = 1'b1;
        step();
        chk_all_zero("post_reset");

        normal_run(40);
        idle_gap();
        normal_run(80);
        idle_gap();

        for (int run = 0; run < 14; run++) begin
            kind = $urandom_range(0, 4);
            arm();
            if (kind == 2) begin
                armed_wander();
                lights = 8'($urandom_range(0, 254));
                button = 1'b1;
                step();
                chk_false_start();
            end else begin
                to_delay(d);
                run_delay(d, (kind == 3) ? 1 : (kind == 4) ? 2 : 0, ok);
                chk("kind_outcome", 32'(ok), (kind <= 1) ? 1 : 0);
                if (ok) run_timing($urandom_range(0, 90));
            end
            idle_gap();
        end

        // Reset while timing, then re-arm from IDLE.
        arm();
        to_delay(d);
        run_delay(d, 0, ok);
        for (int i = 0; i < 9; i++) step();
        chk("pre_rst_time", 32'(react_time), 32'(exp_time(9)));
        rst = 1'b0;
        step();
        chk_all_zero("mid_reset");
        rst = 1'b1;
        step();
        chk_all_zero("after_mid_reset");
        normal_run($urandom_range(0, 70));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
